bcd_digit_formatter: RTL and testbench
======================================

# bcd_digit_formatter

Converts a binary value into per-digit 4-bit codes plus per-digit enables for a row of seven-segment `hex_driver` instances, sitting directly upstream of them. Each digit slice of the outputs drives one driver's `in` and `enable`. A sequential shift-and-add-3 (double-dabble) converter produces decimal digits; a hex mode passes raw nibbles through. Optional leading-zero blanking uses the drivers' enable inputs. Outputs update atomically, so the display never shows a partially converted value.

## Interface
- `WIDTH`, default 16: binary input width.
- `DIGITS`, default 5: number of display digits. Must be ≥ decimal digits of 2^WIDTH−1; elaboration-time error otherwise.

- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  request carries a new value.
- `in_ready`  out  1  block can accept a request.
- `in_data`  in  WIDTH  unsigned value to display.
- `in_hex`  in  1  1 = hex nibbles, 0 = decimal conversion. Sampled with `in_data`.
- `in_blank_lz`  in  1  1 = blank leading zero digits. Sampled with `in_data`.
- `digit`  out  4*DIGITS  digit i occupies bits [4i+3:4i]; digit 0 is least significant.
- `digit_en`  out  DIGITS  per-digit enable for the drivers.
- `out_valid`  out  1  one-cycle pulse when `digit`/`digit_en` take a new value.

## Operation
- States: IDLE, SHIFT, COMMIT.
- `in_ready` = (state == IDLE). A request is accepted on an edge where `in_valid && in_ready`. On acceptance, `in_data`, `in_hex` and `in_blank_lz` are captured.
- IDLE → SHIFT when accepted with `in_hex`=0. This loads the shift register (`in_data`, BCD field zeroed) and sets the iteration counter to WIDTH.
- IDLE → COMMIT when accepted with `in_hex`=1. Result = low 4*DIGITS bits of `in_data`, zero-extended if WIDTH < 4*DIGITS. Excess high bits are dropped.
- SHIFT does one iteration per cycle:
  - Each BCD digit ≥5 gets +3.
  - The whole register then shifts left 1.
  - The counter decrements.
  - After the WIDTH-th iteration → COMMIT.
- COMMIT registers the result into `digit`, computes `digit_en`, asserts `out_valid` for one cycle, and returns to IDLE.
- Blanking:
  - If `in_blank_lz`=0, `digit_en` is all ones.
  - Otherwise, `digit_en[i]`=0 for i≥1 when digits i..DIGITS−1 are all zero.
  - `digit_en[0]` is always 1, so value 0 displays "0".
- `digit`/`digit_en` hold their previous value throughout SHIFT; they change only at COMMIT.
- `in_valid` while busy is ignored, not queued. The upstream holds the request until `in_ready`.
- Reset asserted in any state, including mid-conversion:
  - Next state is IDLE.
  - Conversion is discarded.
  - Outputs take reset values.
  - No `out_valid`.

## Timing
- Reset values: `digit`=0, `digit_en`=all ones, `out_valid`=0, `in_ready`=1, state=IDLE.
- Decimal: acceptance at edge E; outputs and `out_valid` visible after edge E+WIDTH+1 (17 cycles for WIDTH=16); `in_ready` high again the same cycle.
- Hex: acceptance at edge E; outputs and `out_valid` visible after edge E+1; `in_ready` high again the same cycle.
- Back-to-back: a request present when `in_ready` returns is accepted on that cycle's edge. Maximum throughput is one decimal value per WIDTH+2 cycles and one hex value per 2 cycles.
- `in_ready` is combinational from state only. It has no path from `in_valid`.

## Structure
- Package `bcd_pkg`:
  - state enum `fmt_state_t`.
  - constant function `dec_digits(width)` for the DIGITS check.
  - `NIBBLE_W` = 4.
- Sub-module `bcd_dabble_step`: combinational add-3 adjust over DIGITS digits plus the 1-bit shift. Instantiated once; the FSM iterates it.
- Counter width is $clog2(WIDTH+1).

## Test plan
- Decimal, 65535, blank=0 → after 17 cycles, digits (4..0) = 6,5,5,3,5; `digit_en`=11111; one `out_valid` pulse.
- Decimal, 0, blank=1 → digits all 0; `digit_en`=00001. Decimal, 1000, blank=1 → digits 0,1,0,0,0; `digit_en`=01111.
- Hex, 0x00A5, blank=1 → after 2 cycles, digits 0,0,0,A,5; `digit_en`=00011. Hex, 0xBEEF, blank=0 → 0,B,E,E,F; `digit_en`=11111.
- Hold `in_valid` with 12345 then 54321 → second accepted only after `in_ready` returns. Outputs show 12345 unchanged until the second COMMIT; exactly two `out_valid` pulses.
- Reset at iteration 8 of a conversion → outputs return to reset values, no `out_valid`, `in_ready`=1 next cycle. A new request of 42 then converts correctly to 0,0,0,4,2.
- Random WIDTH=16 decimal values (≥1000) compared against a reference model; also check that outputs are stable during SHIFT.

Source files
------------

// File: rtl/bcd_digit_formatter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and helpers for the BCD digit formatter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } fmt_state_t;

    // Number of decimal digits needed to show 2^width-1.
    function automatic int dec_digits(input int width);
        longint unsigned v;
        int              n;
        if (width >= 64) begin
            return (width * 30103) / 100000 + 1;
        end
        v = (64'd1 << width) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dabble_step
// Brief    : One double-dabble iteration: add-3 adjust on every BCD digit,
//            then shift the whole register left by one.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic [NIBBLE_W*DIGITS+WIDTH-1:0] i_shreg,
    output logic [NIBBLE_W*DIGITS+WIDTH-1:0] o_shreg
);

    logic [NIBBLE_W*DIGITS+WIDTH-1:0] w_adj;

    assign w_adj[WIDTH-1:0] = i_shreg[WIDTH-1:0];

    // BCD field sits above the binary field; digit i starts at WIDTH + 4i.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        localparam int c_LO = WIDTH + NIBBLE_W * gi;
        logic [NIBBLE_W-1:0] w_nib;
        assign w_nib = i_shreg[c_LO +: NIBBLE_W];
        assign w_adj[c_LO +: NIBBLE_W] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

    assign o_shreg = w_adj << 1;

endmodule
`default_nettype wire

// File: rtl/bcd_digit_formatter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_formatter
// Brief    : Binary-to-digit formatter feeding a row of hex_driver instances,
//            decimal (iterative double-dabble) or raw hex, with LZ blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_formatter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_hex,
    input  logic                       in_blank_lz,
    output logic [NIBBLE_W*DIGITS-1:0] digit,
    output logic [DIGITS-1:0]          digit_en,
    output logic                       out_valid
);

    localparam int c_BCD_W = NIBBLE_W * DIGITS;
    localparam int c_SR_W  = c_BCD_W + WIDTH;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    if (DIGITS < dec_digits(WIDTH)) begin : g_digits_check
        $error("bcd_digit_formatter: DIGITS too small for WIDTH");
    end

    fmt_state_t           r_state;
    fmt_state_t           w_state_nxt;
    logic [c_SR_W-1:0]    r_shreg;
    logic [c_SR_W-1:0]    w_shreg_step;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_blank;
    logic [c_BCD_W-1:0]   r_digit;
    logic [DIGITS-1:0]    r_digit_en;
    logic                 r_out_valid;
    logic [c_BCD_W-1:0]   w_hex_val;
    logic [c_BCD_W-1:0]   w_bcd;
    logic [DIGITS-1:0]    w_digit_en;
    logic                 w_accept;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;

    if (WIDTH >= c_BCD_W) begin : g_hex_trunc
        assign w_hex_val = in_data[c_BCD_W-1:0];
    end else begin : g_hex_ext
        assign w_hex_val = {{(c_BCD_W-WIDTH){1'b0}}, in_data};
    end

    bcd_dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .i_shreg (r_shreg),
        .o_shreg (w_shreg_step)
    );

    // Hex values are parked in the BCD field so COMMIT has a single source.
    assign w_bcd = r_shreg[c_SR_W-1 -: c_BCD_W];

    assign w_digit_en[0] = 1'b1;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
        assign w_digit_en[gi] = !r_blank || (|w_bcd[c_BCD_W-1:NIBBLE_W*gi]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_hex ? ST_COMMIT : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_blank     <= 1'b0;
            r_digit     <= '0;
            r_digit_en  <= '1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_blank <= in_blank_lz;
                        r_cnt   <= c_CNT_W'(WIDTH);
                        if (in_hex) begin
                            r_shreg <= {w_hex_val, {WIDTH{1'b0}}};
                        end else begin
                            r_shreg <= {{c_BCD_W{1'b0}}, in_data};
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= w_shreg_step;
                    r_cnt   <= r_cnt - c_CNT_W'(1);
                end
                ST_COMMIT: begin
                    r_digit     <= w_bcd;
                    r_digit_en  <= w_digit_en;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign digit     = r_digit;
    assign digit_en  = r_digit_en;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_digit_formatter
// Brief    : Self-checking bench: vector table, scoreboard queue, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_formatter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_hex = 1'b0;
    logic        in_blank_lz = 1'b0;
    logic [19:0] digit;
    logic [4:0]  digit_en;
    logic        out_valid;

    always #5 clk = ~clk;

    bcd_digit_formatter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_hex      (in_hex),
        .in_blank_lz (in_blank_lz),
        .digit       (digit),
        .digit_en    (digit_en),
        .out_valid   (out_valid)
    );

    typedef struct {
        logic [19:0] digit;
        logic [4:0]  en;
        int          cyc;
    } sb_t;

    typedef struct {
        logic [15:0] data;
        logic        hex;
        logic        blank;
        logic [19:0] exp_digit;
        logic [4:0]  exp_en;
    } vec_t;

    sb_t         q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          exp_pulses = 0;
    logic [19:0] last_d = '0;
    logic [4:0]  last_en = '1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] model_digits(input logic [15:0] v, input logic h);
        logic [19:0] r;
        int          t;
        if (h) return {4'h0, v};
        t = int'(v);
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_en(input logic [19:0] d, input logic b);
        logic [4:0] e;
        e = '1;
        if (b) begin
            for (int i = 1; i < 5; i++) begin
                e[i] = ((d >> (4 * i)) != 20'd0);
            end
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer plus hold-stability check while busy.
    always @(negedge clk) begin
        sb_t e;
        if (!reset) begin
            if (out_valid) begin
                pulses++;
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("digit", 32'(digit), 32'(e.digit));
                    check("digit_en", 32'(digit_en), 32'(e.en));
                    check("latency", 32'(cyc), 32'(e.cyc));
                end
                last_d  = digit;
                last_en = digit_en;
            end else if (!in_ready) begin
                check("hold_digit", 32'(digit), 32'(last_d));
                check("hold_en", 32'(digit_en), 32'(last_en));
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic h, input logic b,
                        input logic [19:0] exp_d, input logic [4:0] exp_e,
                        output int acc_cyc);
        sb_t e;
        bit  ok;
        int  waited;
        waited      = 0;
        in_data     = d;
        in_hex      = h;
        in_blank_lz = b;
        in_valid    = 1'b1;
        do begin
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!ok && waited < 100);
        in_valid = 1'b0;
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
            e.digit = exp_d;
            e.en    = exp_e;
            e.cyc   = cyc + (h ? 1 : WIDTH + 1);
            q.push_back(e);
            exp_pulses++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[10];
        int          a0, a1;
        logic [15:0] rd;
        logic        rb;
        logic [19:0] md;

        vecs[0] = '{16'd65535, 1'b0, 1'b0, 20'h65535, 5'b11111};
        vecs[1] = '{16'd0,     1'b0, 1'b1, 20'h00000, 5'b00001};
        vecs[2] = '{16'd1000,  1'b0, 1'b1, 20'h01000, 5'b01111};
        vecs[3] = '{16'h00A5,  1'b1, 1'b1, 20'h000A5, 5'b00011};
        vecs[4] = '{16'hBEEF,  1'b1, 1'b0, 20'h0BEEF, 5'b11111};
        vecs[5] = '{16'd9,     1'b0, 1'b0, 20'h00009, 5'b11111};
        vecs[6] = '{16'hFFFF,  1'b1, 1'b1, 20'h0FFFF, 5'b01111};
        vecs[7] = '{16'd10000, 1'b0, 1'b1, 20'h10000, 5'b11111};
        vecs[8] = '{16'd42,    1'b0, 1'b1, 20'h00042, 5'b00011};
        vecs[9] = '{16'd0,     1'b1, 1'b1, 20'h00000, 5'b00001};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_digit", 32'(digit), 32'd0);
        check("reset_en", 32'(digit_en), 32'h1F);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].data, vecs[i].hex, vecs[i].blank,
                 vecs[i].exp_digit, vecs[i].exp_en, a0);
            wait_drain();
        end

        // Held request: second value only accepted once in_ready returns.
        send(16'd12345, 1'b0, 1'b1, 20'h12345, 5'b11111, a0);
        send(16'd54321, 1'b0, 1'b1, 20'h54321, 5'b11111, a1);
        check("b2b_dec_spacing", 32'(a1 - a0), 32'(WIDTH + 2));
        wait_drain();

        send(16'h1234, 1'b1, 1'b0, 20'h01234, 5'b11111, a0);
        send(16'h0007, 1'b1, 1'b1, 20'h00007, 5'b00001, a1);
        check("b2b_hex_spacing", 32'(a1 - a0), 32'd2);
        wait_drain();

        // Reset in the middle of a conversion discards it.
        send(16'd50000, 1'b0, 1'b1, 20'h50000, 5'b11111, a0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_pulses--;
        last_d  = '0;
        last_en = '1;
        check("midreset_digit", 32'(digit), 32'd0);
        check("midreset_en", 32'(digit_en), 32'h1F);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        send(16'd42, 1'b0, 1'b1, 20'h00042, 5'b00011, a0);
        wait_drain();

        for (int i = 0; i < 8; i++) begin
            rd = 16'($urandom_range(1000, 65535));
            rb = 1'($urandom_range(0, 1));
            md = model_digits(rd, 1'b0);
            send(rd, 1'b0, rb, md, model_en(md, rb), a0);
            wait_drain();
        end

        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
